// File: rtl/aurora_hls_config_monitor_if.sv
// Host-side configuration bus for aurora_hls_config_monitor: the shadow-register write channel
// plus the commit handshake.
interface aurora_hls_config_monitor_if #(
    parameter int unsigned NUM_CHANNELS = 1
);
    localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic              cfg_wr_valid;
    logic              cfg_wr_ready;
    logic [CHAN_W-1:0] cfg_wr_chan;
    logic [1:0]        cfg_wr_addr;
    logic [31:0]       cfg_wr_data;
    logic              cfg_commit;
    logic              cfg_error;
    logic              commit_pending;

    // Host side
    modport master (
        output cfg_wr_valid, cfg_wr_chan, cfg_wr_addr, cfg_wr_data, cfg_commit,
        input  cfg_wr_ready, cfg_error, commit_pending
    );

    // Monitor side
    modport slave (
        input  cfg_wr_valid, cfg_wr_chan, cfg_wr_addr, cfg_wr_data, cfg_commit,
        output cfg_wr_ready, cfg_error, commit_pending
    );
endinterface

// File: rtl/aurora_hls_config_monitor.sv
// Runtime-programmable per-channel Aurora configuration and RX FIFO threshold monitor.
// Host writes land in shadow registers. A commit validates every channel's shadow thresholds
// and then copies all shadows to the active registers on a single edge. The active thresholds
// drive the registered prog_full/prog_empty flags and the saturating prog_full event counters.
module aurora_hls_config_monitor #(
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned CONFIG_WIDTH = 22,
    parameter int unsigned LEVEL_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter logic [CONFIG_WIDTH-1:0] DEFAULT_CONFIG = '0,
    parameter logic [LEVEL_WIDTH-1:0]  DEFAULT_FULL   = LEVEL_WIDTH'(480),
    parameter logic [LEVEL_WIDTH-1:0]  DEFAULT_EMPTY  = LEVEL_WIDTH'(16)
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    aurora_hls_config_monitor_if.slave            cfg,
    output logic [CONFIG_WIDTH*NUM_CHANNELS-1:0]  configuration,
    output logic [2*LEVEL_WIDTH*NUM_CHANNELS-1:0] fifo_thresholds,
    input  logic [LEVEL_WIDTH*NUM_CHANNELS-1:0]   fifo_level,
    output logic [NUM_CHANNELS-1:0]               prog_full,
    output logic [NUM_CHANNELS-1:0]               prog_empty,
    output logic [CNT_WIDTH*NUM_CHANNELS-1:0]     full_events
);
    localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {StIdle = 2'd0, StCheck = 2'd1, StApply = 2'd2} state_e;

    state_e state_q, state_d;

    logic [CONFIG_WIDTH-1:0] shadow_cfg   [NUM_CHANNELS];
    logic [LEVEL_WIDTH-1:0]  shadow_full  [NUM_CHANNELS];
    logic [LEVEL_WIDTH-1:0]  shadow_empty [NUM_CHANNELS];
    logic [CONFIG_WIDTH-1:0] active_cfg   [NUM_CHANNELS];
    logic [LEVEL_WIDTH-1:0]  active_full  [NUM_CHANNELS];
    logic [LEVEL_WIDTH-1:0]  active_empty [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_q        [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] chan_sel;
    logic [NUM_CHANNELS-1:0] clr_cnt;
    logic [NUM_CHANNELS-1:0] full_hit;
    logic [NUM_CHANNELS-1:0] empty_hit;
    logic                    wr_fire;
    logic                    thr_bad;
    logic                    unused_data;

    // Only the LSBs of the write data carry meaning
    assign unused_data = ^cfg.cfg_wr_data;

    // Write decode: out-of-range channels match no slot, so such writes vanish
    always_comb begin
        wr_fire = cfg.cfg_wr_valid & cfg.cfg_wr_ready;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            chan_sel[ch] = wr_fire && (cfg.cfg_wr_chan == CHAN_W'(ch));
            clr_cnt[ch]  = chan_sel[ch] && (cfg.cfg_wr_addr == 2'd3);
        end
    end

    // A commit is rejected if any channel's shadow full threshold does not exceed its empty one
    always_comb begin
        thr_bad = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (shadow_full[ch] <= shadow_empty[ch]) thr_bad = 1'b1;
        end
    end

    // Commit FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Commit FSM next state; a commit outside StIdle is ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg.cfg_commit) state_d = StCheck;
            StCheck: state_d = thr_bad ? StIdle : StApply;
            StApply: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Commit FSM outputs
    always_comb begin
        cfg.cfg_wr_ready   = (state_q == StIdle);
        cfg.commit_pending = (state_q != StIdle);
        cfg.cfg_error      = (state_q == StCheck) && thr_bad;
    end

    // Shadow registers; a write in the commit cycle is sampled before the check
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                shadow_cfg[ch]   <= DEFAULT_CONFIG;
                shadow_full[ch]  <= DEFAULT_FULL;
                shadow_empty[ch] <= DEFAULT_EMPTY;
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (chan_sel[ch]) begin
                    case (cfg.cfg_wr_addr)
                        2'd0:    shadow_cfg[ch]   <= cfg.cfg_wr_data[CONFIG_WIDTH-1:0];
                        2'd1:    shadow_full[ch]  <= cfg.cfg_wr_data[LEVEL_WIDTH-1:0];
                        2'd2:    shadow_empty[ch] <= cfg.cfg_wr_data[LEVEL_WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active registers: all channels switch together on the edge leaving StApply
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                active_cfg[ch]   <= DEFAULT_CONFIG;
                active_full[ch]  <= DEFAULT_FULL;
                active_empty[ch] <= DEFAULT_EMPTY;
            end
        end else if (state_q == StApply) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                active_cfg[ch]   <= shadow_cfg[ch];
                active_full[ch]  <= shadow_full[ch];
                active_empty[ch] <= shadow_empty[ch];
            end
        end
    end

    // Unsigned level comparisons against the active thresholds
    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            full_hit[ch]  = fifo_level[ch*LEVEL_WIDTH +: LEVEL_WIDTH] >= active_full[ch];
            empty_hit[ch] = fifo_level[ch*LEVEL_WIDTH +: LEVEL_WIDTH] <= active_empty[ch];
        end
    end

    // Registered flags and rising-edge counters; a clear beats a coincident increment
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prog_full  <= '0;
            prog_empty <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) cnt_q[ch] <= '0;
        end else begin
            prog_full  <= full_hit;
            prog_empty <= empty_hit;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (clr_cnt[ch]) begin
                    cnt_q[ch] <= '0;
                end else if (full_hit[ch] && !prog_full[ch] && (cnt_q[ch] != '1)) begin
                    cnt_q[ch] <= cnt_q[ch] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Pack per-channel state onto the flat output buses, channel 0 in the LSBs
    always_comb begin
        configuration   = '0;
        fifo_thresholds = '0;
        full_events     = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            configuration[ch*CONFIG_WIDTH +: CONFIG_WIDTH]       = active_cfg[ch];
            fifo_thresholds[ch*2*LEVEL_WIDTH +: 2*LEVEL_WIDTH]   = {active_full[ch],
                                                                    active_empty[ch]};
            full_events[ch*CNT_WIDTH +: CNT_WIDTH]               = cnt_q[ch];
        end
    end
endmodule

// File: tb/tb_aurora_hls_config_monitor.sv
// Scoreboard bench for aurora_hls_config_monitor with three channels. Stimulus pushes the
// expected value of an output with the cycle it is due; the monitor pops and compares on the
// falling edge of that cycle.
module tb_aurora_hls_config_monitor;
    localparam int unsigned NCH = 3;

    localparam int K_CFG  = 0;
    localparam int K_THR  = 1;
    localparam int K_PF   = 2;
    localparam int K_PE   = 3;
    localparam int K_EVT  = 4;
    localparam int K_ERR  = 5;
    localparam int K_RDY  = 6;
    localparam int K_PEND = 7;

    typedef struct {
        int          due;
        int          kind;
        int          ch;
        logic [95:0] val;
        string       name;
    } item_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [65:0]   configuration;
    logic [95:0]   fifo_thresholds;
    logic [47:0]   fifo_level = '0;
    logic [2:0]    prog_full;
    logic [2:0]    prog_empty;
    logic [95:0]   full_events;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    final_req = 1'b0;
    bit    final_done = 1'b0;
    item_t sb[$];

    aurora_hls_config_monitor_if #(.NUM_CHANNELS(NCH)) bus ();

    aurora_hls_config_monitor #(
        .NUM_CHANNELS(NCH)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .cfg             (bus),
        .configuration   (configuration),
        .fifo_thresholds (fifo_thresholds),
        .fifo_level      (fifo_level),
        .prog_full       (prog_full),
        .prog_empty      (prog_empty),
        .full_events     (full_events)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    function automatic logic [95:0] sample(input int kind, input int ch);
        case (kind)
            K_CFG:   return 96'(configuration);
            K_THR:   return 96'(fifo_thresholds[ch*32 +: 32]);
            K_PF:    return 96'(prog_full);
            K_PE:    return 96'(prog_empty);
            K_EVT:   return 96'(full_events[ch*32 +: 32]);
            K_ERR:   return 96'(bus.cfg_error);
            K_RDY:   return 96'(bus.cfg_wr_ready);
            default: return 96'(bus.commit_pending);
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due this cycle
    always @(negedge ap_clk) begin
        logic [95:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                act = sample(sb[i].kind, sb[i].ch);
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %0h want %0h", sb[i].name, cyc, act,
                             sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (final_req && !final_done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drained: got %0d entries left want 0", sb.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic expect_at(input int kind, input int ch, input logic [95:0] val,
                             input int delay, input string name);
        item_t it;
        it.due  = cyc + delay;
        it.kind = kind;
        it.ch   = ch;
        it.val  = val;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_chan  = ch[1:0];
        bus.cfg_wr_addr  = addr[1:0];
        bus.cfg_wr_data  = data;
        tick();
        bus.cfg_wr_valid = 1'b0;
    endtask

    task automatic set_level(input int ch, input logic [15:0] lvl);
        fifo_level[ch*16 +: 16] = lvl;
    endtask

    initial begin
        bus.cfg_wr_valid = 1'b0;
        bus.cfg_wr_chan  = '0;
        bus.cfg_wr_addr  = '0;
        bus.cfg_wr_data  = '0;
        bus.cfg_commit   = 1'b0;

        // Reset values while reset is held
        repeat (3) tick();
        expect_at(K_CFG, 0, 96'h0, 0, "rst_config");
        for (int ch = 0; ch < 3; ch++) expect_at(K_THR, ch, {64'h0, 16'd480, 16'd16}, 0,
                                                 "rst_thresholds");
        expect_at(K_PF, 0, 96'h0, 0, "rst_prog_full");
        expect_at(K_PE, 0, 96'h0, 0, "rst_prog_empty");
        expect_at(K_EVT, 0, 96'h0, 0, "rst_events");
        expect_at(K_ERR, 0, 96'h0, 0, "rst_error");
        expect_at(K_RDY, 0, 96'h1, 0, "rst_ready");
        expect_at(K_PEND, 0, 96'h0, 0, "rst_pending");
        @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        expect_at(K_PE, 0, 96'h7, 1, "post_rst_prog_empty");
        expect_at(K_PF, 0, 96'h0, 1, "post_rst_prog_full");
        tick();

        // Valid commit: full=100, empty=10 on ch0
        wr(0, 1, 100);
        wr(0, 2, 10);
        expect_at(K_THR, 0, {64'h0, 16'd480, 16'd16}, 0, "shadow_not_active");
        bus.cfg_commit = 1'b1;
        expect_at(K_RDY, 0, 96'h0, 1, "ready_in_check");
        expect_at(K_RDY, 0, 96'h0, 2, "ready_in_apply");
        expect_at(K_RDY, 0, 96'h1, 3, "ready_after_apply");
        expect_at(K_PEND, 0, 96'h1, 1, "pending_check");
        expect_at(K_PEND, 0, 96'h1, 2, "pending_apply");
        expect_at(K_PEND, 0, 96'h0, 3, "pending_done");
        expect_at(K_ERR, 0, 96'h0, 1, "no_error_good_commit");
        expect_at(K_THR, 0, {64'h0, 16'd480, 16'd16}, 2, "thr_before_apply");
        expect_at(K_THR, 0, {64'h0, 16'd100, 16'd10}, 3, "thr_after_apply");
        tick();
        bus.cfg_commit = 1'b0;
        tick();
        tick();
        set_level(0, 16'd100);
        expect_at(K_PF, 0, 96'h1, 1, "full_at_threshold");
        expect_at(K_PE, 0, 96'h6, 1, "empty_ch0_clear");
        expect_at(K_EVT, 0, 96'h1, 1, "first_event");
        tick();
        set_level(0, 16'd99);
        expect_at(K_PF, 0, 96'h0, 1, "full_below_threshold");
        expect_at(K_PE, 0, 96'h6, 1, "empty_ch0_above");
        tick();

        // Rejected commit: full == empty
        wr(0, 1, 5);
        wr(0, 2, 5);
        bus.cfg_commit = 1'b1;
        expect_at(K_RDY, 0, 96'h0, 1, "bad_ready_low");
        expect_at(K_ERR, 0, 96'h1, 1, "bad_error_pulse");
        expect_at(K_PEND, 0, 96'h1, 1, "bad_pending");
        expect_at(K_RDY, 0, 96'h1, 2, "bad_ready_back");
        expect_at(K_ERR, 0, 96'h0, 2, "bad_error_single");
        expect_at(K_PEND, 0, 96'h0, 2, "bad_pending_clear");
        expect_at(K_THR, 0, {64'h0, 16'd100, 16'd10}, 2, "bad_thr_kept");
        expect_at(K_THR, 0, {64'h0, 16'd100, 16'd10}, 3, "bad_thr_kept_later");
        tick();
        bus.cfg_commit = 1'b0;
        tick();
        tick();

        // Event counting, then clear coincident with a rise
        wr(0, 3, 0);
        expect_at(K_EVT, 0, 96'h0, 0, "evt_cleared");
        for (int i = 0; i < 3; i++) begin
            set_level(0, 16'd500);
            expect_at(K_EVT, 0, 96'(i + 1), 1, "evt_count");
            expect_at(K_PF, 0, 96'h1, 1, "evt_flag_high");
            tick();
            set_level(0, 16'd0);
            expect_at(K_PF, 0, 96'h0, 1, "evt_flag_low");
            tick();
        end
        expect_at(K_EVT, 0, 96'h3, 0, "evt_three");
        set_level(0, 16'd500);
        wr(0, 3, 0);
        expect_at(K_EVT, 0, 96'h0, 0, "clear_beats_increment");
        expect_at(K_PF, 0, 96'h1, 0, "fourth_rise_flag");
        set_level(0, 16'd0);
        tick();

        // Multi-channel atomic apply; write in the commit cycle joins the commit
        wr(0, 1, 480);
        wr(0, 2, 16);
        wr(0, 0, 32'h11111);
        wr(1, 0, 32'h22222);
        wr(2, 0, 32'h33333);
        wr(3, 0, 32'h3FFFFF);
        wr(3, 1, 1);
        expect_at(K_THR, 0, {64'h0, 16'd100, 16'd10}, 0, "shadow_writes_hidden");
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_chan  = 2'd1;
        bus.cfg_wr_addr  = 2'd0;
        bus.cfg_wr_data  = 32'h2ABCD;
        bus.cfg_commit   = 1'b1;
        expect_at(K_ERR, 0, 96'h0, 1, "discarded_bad_thr");
        expect_at(K_CFG, 0, 96'h0, 2, "cfg_before_apply");
        expect_at(K_CFG, 0, 96'({22'h33333, 22'h2ABCD, 22'h11111}), 3, "cfg_all_apply");
        expect_at(K_THR, 0, {64'h0, 16'd480, 16'd16}, 3, "thr_restored");
        expect_at(K_PEND, 0, 96'h1, 2, "multi_pending");
        expect_at(K_PEND, 0, 96'h0, 3, "multi_pending_done");
        expect_at(K_PEND, 0, 96'h0, 4, "commit_in_check_ignored");
        expect_at(K_RDY, 0, 96'h1, 4, "ready_after_ignored");
        tick();
        bus.cfg_wr_valid = 1'b0;
        tick();
        bus.cfg_commit = 1'b0;
        tick();
        tick();

        // Reset while in CHECK
        wr(0, 0, 32'h155);
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        expect_at(K_CFG, 0, 96'h0, 0, "midrst_config");
        expect_at(K_THR, 0, {64'h0, 16'd480, 16'd16}, 0, "midrst_thr");
        expect_at(K_PEND, 0, 96'h0, 0, "midrst_pending");
        expect_at(K_ERR, 0, 96'h0, 0, "midrst_no_error");
        expect_at(K_RDY, 0, 96'h1, 0, "midrst_ready");
        expect_at(K_PE, 0, 96'h0, 0, "midrst_prog_empty");
        tick();
        ap_rst_n = 1'b1;
        expect_at(K_RDY, 0, 96'h1, 0, "ready_after_release");
        tick();
        bus.cfg_commit = 1'b1;
        expect_at(K_ERR, 0, 96'h0, 1, "post_rst_commit_ok");
        expect_at(K_CFG, 0, 96'h0, 3, "shadow_reset_to_default");
        expect_at(K_PEND, 0, 96'h0, 3, "post_rst_commit_done");
        tick();
        bus.cfg_commit = 1'b0;
        repeat (4) tick();

        final_req = 1'b1;
        repeat (2) @(negedge ap_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
